// File: rtl/rnn_pkg.sv
// Shared types, register map and saturation helper for the Elman RNN cell.
package rnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_MAC, S_ACT, S_SWAP, S_DENSE, S_DWR, S_DONE
    } state_t;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd0;
    localparam logic [3:0] A_X      = 4'd1;
    localparam logic [3:0] A_WX     = 4'd2;
    localparam logic [3:0] A_WH     = 4'd3;
    localparam logic [3:0] A_B      = 4'd4;
    localparam logic [3:0] A_D      = 4'd5;
    localparam logic [3:0] A_DB     = 4'd6;
    localparam logic [3:0] A_Y      = 4'd7;
    localparam logic [3:0] A_SEL    = 4'd8;
    localparam logic [3:0] A_H      = 4'd9;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_DENSE = 2;

    localparam int ST_BUSY  = 0;
    localparam int ST_VALID = 1;
    localparam int ST_ERR   = 2;

    localparam int ACT_HTANH = 0;
    localparam int ACT_IDENT = 1;
    localparam int ACT_RELU  = 2;

    localparam int SAT_W = 64;

    // Clamp a wide signed value into the range of a w-bit two's complement number.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v, input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fx_mac.sv
// Signed DWxDW multiply-accumulate; result is sat((acc >>> FRAC) + bias).
module fx_mac
    import rnn_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int AW   = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] bias,
    output logic signed [DW-1:0] res
);

    logic signed [2*DW-1:0]  prod;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    shifted;
    logic signed [SAT_W-1:0] sum;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
    end

    assign shifted = acc >>> FRAC;
    assign sum     = {{(SAT_W-AW){shifted[AW-1]}}, shifted} + {{(SAT_W-DW){bias[DW-1]}}, bias};
    assign res     = DW'(sat(sum, DW));

endmodule

// File: rtl/rnn_cell_p.sv
// Elman RNN cell: h' = act(b + Wx*x + Wh*h), optional dense head y = db + D*h',
// all computed serially through one shared fixed-point MAC.
module rnn_cell_p
    import rnn_pkg::*;
#(
    parameter int DW     = 16,
    parameter int FRAC   = 8,
    parameter int EMB    = 4,
    parameter int HID    = 8,
    parameter int OUT_CH = 2,
    parameter int ACT    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int NK = EMB + HID;
    localparam int CW = $clog2(NK + 1);
    localparam int AW = 2*DW + $clog2(NK);
    localparam int EW = (EMB > 1) ? $clog2(EMB) : 1;
    localparam int HW = (HID > 1) ? $clog2(HID) : 1;
    localparam int OW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam logic signed [DW-1:0] ONE     = DW'(1 << FRAC);
    localparam logic signed [DW-1:0] NEG_ONE = -ONE;

    logic signed [DW-1:0] x_mem  [EMB];
    logic signed [DW-1:0] wx     [EMB][HID];
    logic signed [DW-1:0] wh     [HID][HID];
    logic signed [DW-1:0] b_mem  [HID];
    logic signed [DW-1:0] d_mem  [OUT_CH][HID];
    logic signed [DW-1:0] db_mem [OUT_CH];
    logic signed [DW-1:0] y_mem  [OUT_CH];
    logic signed [DW-1:0] h_mem  [2][HID];

    state_t        state;
    logic          busy, valid, err, dense_en, bank;
    logic [7:0]    sel;
    logic [CW-1:0] k, kh;
    logic [HW-1:0] j;
    logic [OW-1:0] c;

    logic [7:0]           row, col;
    logic signed [DW-1:0] val;
    logic signed [DW-1:0] op_a, op_b, bias, mac_res, act_val, rd_v;
    logic                 mac_en, rd_hit;

    assign row = data_in[31:24];
    assign col = data_in[23:16];
    assign val = data_in[DW-1:0];
    assign kh  = k - CW'(EMB);

    // Input terms come first (k < EMB), then recurrent terms from the active bank.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state == S_MAC) begin
            if (k < CW'(EMB)) begin
                op_a = x_mem[EW'(k)];
                op_b = wx[EW'(k)][j];
            end else begin
                op_a = h_mem[bank][HW'(kh)];
                op_b = wh[HW'(kh)][j];
            end
        end else if (state == S_DENSE) begin
            op_a = h_mem[bank][HW'(k)];
            op_b = d_mem[c][HW'(k)];
        end
    end

    assign bias   = (state == S_DWR) ? db_mem[c] : b_mem[j];
    assign mac_en = (state == S_MAC) || (state == S_DENSE);

    fx_mac #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (!mac_en),
        .en   (mac_en),
        .a    (op_a),
        .b    (op_b),
        .bias (bias),
        .res  (mac_res)
    );

    always_comb begin
        act_val = mac_res;
        if (ACT == ACT_HTANH) begin
            if (mac_res > ONE)          act_val = ONE;
            else if (mac_res < NEG_ONE) act_val = NEG_ONE;
        end else if (ACT == ACT_RELU && mac_res[DW-1]) begin
            act_val = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            dense_en <= 1'b0;
            bank     <= 1'b0;
            sel      <= '0;
            k        <= '0;
            j        <= '0;
            c        <= '0;
            for (int i = 0; i < EMB; i++) begin
                x_mem[i] <= '0;
                for (int n = 0; n < HID; n++) wx[i][n] <= '0;
            end
            for (int i = 0; i < HID; i++) begin
                b_mem[i]    <= '0;
                h_mem[0][i] <= '0;
                h_mem[1][i] <= '0;
                for (int n = 0; n < HID; n++) wh[i][n] <= '0;
            end
            for (int i = 0; i < OUT_CH; i++) begin
                db_mem[i] <= '0;
                y_mem[i]  <= '0;
                for (int n = 0; n < HID; n++) d_mem[i][n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (write) begin
                    case (addr)
                        A_CTRL: begin
                            if (data_in[CTRL_CLR]) begin
                                valid <= 1'b0;
                                for (int i = 0; i < HID; i++) begin
                                    h_mem[0][i] <= '0;
                                    h_mem[1][i] <= '0;
                                end
                            end
                            if (data_in[CTRL_START]) begin
                                valid    <= 1'b0;
                                err      <= 1'b0;
                                busy     <= 1'b1;
                                dense_en <= data_in[CTRL_DENSE];
                                k        <= '0;
                                j        <= '0;
                                c        <= '0;
                                state    <= S_MAC;
                            end
                        end
                        A_X:  if ({1'b0, col} < 9'(EMB)) x_mem[EW'(col)] <= val;
                        A_WX: if ({1'b0, row} < 9'(EMB) && {1'b0, col} < 9'(HID))
                                  wx[EW'(row)][HW'(col)] <= val;
                        A_WH: if ({1'b0, row} < 9'(HID) && {1'b0, col} < 9'(HID))
                                  wh[HW'(row)][HW'(col)] <= val;
                        A_B:  if ({1'b0, col} < 9'(HID)) b_mem[HW'(col)] <= val;
                        A_D:  if ({1'b0, row} < 9'(OUT_CH) && {1'b0, col} < 9'(HID))
                                  d_mem[OW'(row)][HW'(col)] <= val;
                        A_DB: if ({1'b0, row} < 9'(OUT_CH)) db_mem[OW'(row)] <= val;
                        default: ;
                    endcase
                end
                S_MAC: begin
                    if (k == CW'(NK - 1)) begin
                        k     <= '0;
                        state <= S_ACT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_ACT: begin
                    h_mem[~bank][j] <= act_val;
                    if (j == HW'(HID - 1)) begin
                        state <= S_SWAP;
                    end else begin
                        j     <= j + 1'b1;
                        state <= S_MAC;
                    end
                end
                S_SWAP: begin
                    bank  <= ~bank;
                    k     <= '0;
                    c     <= '0;
                    state <= dense_en ? S_DENSE : S_DONE;
                end
                S_DENSE: begin
                    if (k == CW'(HID - 1)) begin
                        k     <= '0;
                        state <= S_DWR;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DWR: begin
                    y_mem[c] <= mac_res;
                    if (c == OW'(OUT_CH - 1)) begin
                        state <= S_DONE;
                    end else begin
                        c     <= c + 1'b1;
                        state <= S_DENSE;
                    end
                end
                S_DONE: begin
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Parameter and control writes are rejected while a step runs; SEL never is.
            if (write && state != S_IDLE && addr <= A_DB)
                err <= 1'b1;
            if (write && addr == A_SEL)
                sel <= data_in[7:0];
        end
    end

    always_comb begin
        data_out = '0;
        rd_v     = '0;
        rd_hit   = 1'b0;
        if (read) begin
            case (addr)
                A_STATUS: data_out = {29'b0, err, valid, busy};
                A_Y: if ({1'b0, sel} < 9'(OUT_CH)) begin
                    rd_v   = y_mem[OW'(sel)];
                    rd_hit = 1'b1;
                end
                A_H: if ({1'b0, sel} < 9'(HID)) begin
                    rd_v   = h_mem[bank][HW'(sel)];
                    rd_hit = 1'b1;
                end
                default: ;
            endcase
            if (rd_hit)
                data_out = {{(32-DW){rd_v[DW-1]}}, rd_v};
        end
    end

endmodule
